alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter M, default 7, giving the operand and result width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port data_in, input, M bits: operand value presented by the user.
REQ-005 Port op_in, input, 2 bits: opcode. 00 = SUB (A-B), 01 = ADD, 10 = OR, 11 = AND.
REQ-006 Port load, input, 1 bit: single-cycle pulse, already debounced, that captures the current entry.
REQ-007 Port cancel, input, 1 bit: aborts the entry sequence.
REQ-008 Port result, output, M bits: registered ALU result.
REQ-009 Port flags, output, 5 bits: registered flags, ordered {N,Z,C,V,P}, bit4 = N.
REQ-010 Port valid, output, 1 bit: high while result and flags hold a completed operation.
REQ-011 Port state_o, output, 3 bits: current FSM state encoding, for LEDs.

Function
REQ-012 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, COMPUTE and SHOW.
REQ-013 WAIT_A: load SHALL capture data_in into opA and go to WAIT_B; otherwise stay.
REQ-014 WAIT_B: load SHALL capture data_in into opB and go to WAIT_OP.
REQ-015 WAIT_OP: load SHALL capture op_in and go to COMPUTE.
REQ-016 COMPUTE: lasts exactly 1 cycle, registers result and flags, then goes to SHOW; load is ignored.
REQ-017 Latency: with load sampled at edge k in WAIT_OP, result, flags and valid=1 SHALL be visible after edge k+1.
REQ-018 SHOW: result, flags and valid=1 SHALL hold until the next load, cancel or reset.
REQ-019 SHOW with load (no accumulator): capture data_in into opA, clear valid, go to WAIT_B.
REQ-020 valid SHALL be 0 in every state except SHOW.
REQ-021 cancel SHALL move any state to WAIT_A next cycle and clear valid; result and flags are unchanged.
REQ-022 If cancel and load are high together, cancel SHALL win.
REQ-023 Arithmetic SHALL be evaluated at M+1 bits, with result taken as bits [M-1:0].
REQ-024 C (ADD) SHALL be the carry-out, bit M.
REQ-025 C (SUB) SHALL be bit M of the (M+1)-bit A-B, i.e. 1 when A<B unsigned.
REQ-026 V (ADD) SHALL be 1 when the operands have equal signs and the result sign differs.
REQ-027 V (SUB) SHALL be 1 when the operand signs differ and the result sign differs from A.
REQ-028 C and V SHALL be 0 for OR and AND.
REQ-029 Z SHALL be 1 iff result == 0.
REQ-030 N SHALL equal result[M-1].
REQ-031 P SHALL be the reduction XOR of result (1 for an odd count of ones).
REQ-032 Arithmetic SHALL wrap modulo 2^M with no saturation.

Reset
REQ-033 reset SHALL set: state WAIT_A, result 0, flags 0, valid 0, opA/opB/op 0.
REQ-034 reset SHALL take priority over cancel and load.
REQ-035 reset mid-sequence (including COMPUTE) SHALL discard the partial entry and produce no SHOW.

Configuration
REQ-036 With macro ALU_SEQ_ACCUMULATOR_EN defined, load in SHOW SHALL copy the current result into opA, capture data_in into opB, and go to WAIT_OP.
REQ-037 Without ALU_SEQ_ACCUMULATOR_EN, REQ-019 SHALL apply; there is no result feedback path.

Structure
REQ-038 Package alu_pkg SHALL hold:
- opcode enum (SUB, ADD, OR, AND);
- state enum;
- flag bit index constants FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_P=0.
REQ-039 The combinational ALU SHALL be a sub-module alu_core (parameter M), instantiated once; alu_sequencer owns all registers and the FSM.

Verification (M=7)
REQ-040 Load 5, 3, op 01 -> after 2 edges, result=8, flags=5'b00001, valid=1.
REQ-041 Load 3, 5, op 00 -> result=7'h7E, flags=5'b10100.
REQ-042 Load 63, 1, op 01 -> result=7'h40, flags=5'b10011; then load 7'h55, 7'h2A, op 11 -> result=0, flags=5'b01000.
REQ-043 In WAIT_OP, cancel and load together -> state WAIT_A, valid=0, previous result/flags unchanged.
REQ-044 reset asserted during COMPUTE -> next cycle state WAIT_A, result=0, flags=0, valid=0.
REQ-045 With ALU_SEQ_ACCUMULATOR_EN defined: after 5+3=8 in SHOW, load data_in=2, then load op 01 -> result=10, flags=5'b00000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU entry sequencer: opcodes, FSM states
// and bit positions within the flags word.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_ADD = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SHOW    = 3'd4
    } state_e;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational M-bit ALU producing a result and {N,Z,C,V,P} flags.
// Arithmetic is done one bit wider so the carry/borrow falls out as bit M.
module alu_core
    import alu_pkg::*;
#(
    parameter int M = 7
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  opcode_e      op,
    output logic [M-1:0] res,
    output logic [4:0]   flags
);

    logic [M:0] ext;
    logic       c;
    logic       v;

    always_comb begin
        ext = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                c   = ext[M];
                v   = (a[M-1] != b[M-1]) && (ext[M-1] != a[M-1]);
            end
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                c   = ext[M];
                v   = (a[M-1] == b[M-1]) && (ext[M-1] != a[M-1]);
            end
            OP_OR:   ext = {1'b0, a | b};
            OP_AND:  ext = {1'b0, a & b};
            default: ext = '0;
        endcase
    end

    assign res = ext[M-1:0];

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = res[M-1];
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_P] = ^res;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Operand/opcode entry sequencer around alu_core: A, B, op are loaded one at a
// time, then the result is registered and shown. Define ALU_SEQ_ACCUMULATOR_EN
// to make a load in SHOW chain the shown result in as the next A operand.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int M = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] data_in,
    input  logic [1:0]   op_in,
    input  logic         load,
    input  logic         cancel,
    output logic [M-1:0] result,
    output logic [4:0]   flags,
    output logic         valid,
    output logic [2:0]   state_o
);

    state_e         state, state_nxt;
    logic [M-1:0]   opa, opa_nxt;
    logic [M-1:0]   opb, opb_nxt;
    opcode_e        op, op_nxt;
    logic           res_we;
    logic [M-1:0]   alu_res;
    logic [4:0]     alu_flags;

    alu_core #(.M(M)) u_alu (
        .a     (opa),
        .b     (opb),
        .op    (op),
        .res   (alu_res),
        .flags (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WAIT_A;
            opa    <= '0;
            opb    <= '0;
            op     <= OP_SUB;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            op    <= op_nxt;
            if (res_we) begin
                result <= alu_res;
                flags  <= alu_flags;
            end
        end
    end

    // Cancel outranks load in every state, COMPUTE included, so an abort there
    // leaves the previously shown result untouched.
    always_comb begin
        state_nxt = state;
        opa_nxt   = opa;
        opb_nxt   = opb;
        op_nxt    = op;
        res_we    = 1'b0;
        if (cancel) begin
            state_nxt = WAIT_A;
        end else begin
            case (state)
                WAIT_A: if (load) begin
                    opa_nxt   = data_in;
                    state_nxt = WAIT_B;
                end
                WAIT_B: if (load) begin
                    opb_nxt   = data_in;
                    state_nxt = WAIT_OP;
                end
                WAIT_OP: if (load) begin
                    op_nxt    = opcode_e'(op_in);
                    state_nxt = COMPUTE;
                end
                COMPUTE: begin
                    res_we    = 1'b1;
                    state_nxt = SHOW;
                end
                SHOW: if (load) begin
`ifdef ALU_SEQ_ACCUMULATOR_EN
                    opa_nxt   = result;
                    opb_nxt   = data_in;
                    state_nxt = WAIT_OP;
`else
                    opa_nxt   = data_in;
                    state_nxt = WAIT_B;
`endif
                end
                default: state_nxt = WAIT_A;
            endcase
        end
    end

    assign valid   = (state == SHOW);
    assign state_o = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (M=7); exercises the
// ALU_SEQ_ACCUMULATOR_EN path when that macro is defined.
module tb_alu_sequencer;

    localparam int M = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic [M-1:0] data_in;
    logic [1:0]   op_in;
    logic         load;
    logic         cancel;
    logic [M-1:0] result;
    logic [4:0]   flags;
    logic         valid;
    logic [2:0]   state_o;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.M(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .op_in   (op_in),
        .load    (load),
        .cancel  (cancel),
        .result  (result),
        .flags   (flags),
        .valid   (valid),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [M-1:0] d, input logic [1:0] o);
        data_in = d;
        op_in   = o;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        data_in = '0;
        op_in   = 2'b00;
        load    = 1'b0;
        cancel  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", state_o, 3'd0);
        check("rst_result", result, 7'h00);
        check("rst_flags", flags, 5'b00000);
        check("rst_valid", valid, 1'b0);

        // 5 + 3
        do_load(7'd5, 2'b00);
        check("wait_b", state_o, 3'd1);
        do_load(7'd3, 2'b00);
        check("wait_op", state_o, 3'd2);
        do_load(7'd0, 2'b01);
        check("compute_state", state_o, 3'd3);
        check("compute_valid", valid, 1'b0);
        tick();
        check("add_state", state_o, 3'd4);
        check("add_result", result, 7'd8);
        check("add_flags", flags, 5'b00001);
        check("add_valid", valid, 1'b1);
        tick();
        check("show_hold_result", result, 7'd8);
        check("show_hold_valid", valid, 1'b1);

`ifdef ALU_SEQ_ACCUMULATOR_EN
        do_load(7'd2, 2'b00);
        check("acc_state", state_o, 3'd2);
        check("acc_valid", valid, 1'b0);
        do_load(7'd0, 2'b01);
        tick();
        check("acc_result", result, 7'd10);
        check("acc_flags", flags, 5'b00000);
        check("acc_valid_show", valid, 1'b1);
        do_cancel();
        check("acc_cancel_state", state_o, 3'd0);
        check("acc_cancel_result", result, 7'd10);
`else
        do_load(7'd3, 2'b00);
        check("show_load_state", state_o, 3'd1);
        check("show_load_valid", valid, 1'b0);
        do_cancel();
        check("cancel_state", state_o, 3'd0);
        check("cancel_valid", valid, 1'b0);
        check("cancel_result", result, 7'd8);
        check("cancel_flags", flags, 5'b00001);
`endif

        // 3 - 5
        do_load(7'd3, 2'b00);
        do_load(7'd5, 2'b00);
        do_load(7'd0, 2'b00);
        tick();
        check("sub_result", result, 7'h7E);
        check("sub_flags", flags, 5'b10100);
        do_cancel();

        // 63 + 1 signed overflow
        do_load(7'd63, 2'b00);
        do_load(7'd1, 2'b00);
        do_load(7'd0, 2'b01);
        tick();
        check("ovf_result", result, 7'h40);
        check("ovf_flags", flags, 5'b10011);
        do_cancel();

        // 0x55 AND 0x2A
        do_load(7'h55, 2'b00);
        do_load(7'h2A, 2'b00);
        do_load(7'd0, 2'b11);
        tick();
        check("and_result", result, 7'h00);
        check("and_flags", flags, 5'b01000);
        do_cancel();

        // 0x55 OR 0x2A
        do_load(7'h55, 2'b00);
        do_load(7'h2A, 2'b00);
        do_load(7'd0, 2'b10);
        tick();
        check("or_result", result, 7'h7F);
        check("or_flags", flags, 5'b10001);
        do_cancel();

        // cancel and load together in WAIT_OP
        do_load(7'd1, 2'b00);
        do_load(7'd2, 2'b00);
        cancel = 1'b1;
        do_load(7'd0, 2'b01);
        cancel = 1'b0;
        check("cl_state", state_o, 3'd0);
        check("cl_valid", valid, 1'b0);
        check("cl_result", result, 7'h7F);
        check("cl_flags", flags, 5'b10001);
        tick();
        check("cl_stay", state_o, 3'd0);

        // reset during COMPUTE
        do_load(7'd1, 2'b00);
        do_load(7'd1, 2'b00);
        do_load(7'd0, 2'b01);
        check("pre_rst_compute", state_o, 3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rc_state", state_o, 3'd0);
        check("rc_result", result, 7'h00);
        check("rc_flags", flags, 5'b00000);
        check("rc_valid", valid, 1'b0);
        tick();
        check("rc_no_show", state_o, 3'd0);
        check("rc_no_valid", valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
